duty_sequencer: RTL
===================

Name: duty_sequencer

Overview:
- Programmable sequencer for the 8-slot PWM frame datapath: 3-bit frame counter, thermometer duty mask, and per-slot output select.
- Holds a small table of (duty level, repeat count) entries and plays them back frame by frame.
- Generates the frame position, the current level, and the PWM output bit.
- Sits between a host/config interface (valid/ready writes, start/stop/clear) and the PWM output pin.

Parameters:
- DEPTH, 8: number of table entries (power of 2, max 16).
- LVL_W, 3: duty-level width; frame length is 2**LVL_W.
- REP_W, 4: repeat-count width per entry.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  table-write request.
- wr_ready  out  1  table accepts a write this cycle.
- wr_level  in  LVL_W  duty level; output is high for level+1 slots of the frame.
- wr_repeat  in  REP_W  entry plays for wr_repeat+1 frames.
- clear  in  1  empty the table (IDLE only).
- start  in  1  begin playback (IDLE only).
- stop  in  1  request early termination (RUN only).
- busy  out  1  high in RUN and FINISH.
- done  out  1  one-cycle pulse in FINISH.
- level  out  LVL_W  level of the entry currently playing.
- frame_pos  out  LVL_W  slot index within the frame.
- frame_start  out  1  high when in RUN and frame_pos==0.
- o  out  1  PWM output.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; count, idx, rep_cnt, frame_pos, level and stop_pend all 0.
  - o, done, busy and frame_start are 0.
  - Table contents are don't-care.
  - Reset mid-RUN aborts immediately with no done pulse.
- States: IDLE, RUN, FINISH.
- IDLE:
  - wr_ready = (count<DEPTH) && !clear.
  - A write occurs when wr_valid && wr_ready: the entry is stored at table[count] and count increments.
  - clear sets count=0 next cycle; clear wins over a simultaneous write and over start.
  - start with (count+accepted write)>0 → RUN next cycle with idx=0, rep_cnt=table[0].repeat, frame_pos=0.
  - A write accepted in the same cycle as start is included in the run.
  - start with an empty table (and no write that cycle) is ignored and stays in IDLE.
  - o=0 in IDLE.
- RUN:
  - wr_ready=0; writes are refused.
  - frame_pos increments every cycle, wrapping 7→0.
  - level = table[idx].level.
  - o = (frame_pos <= level), registered so it aligns with frame_pos. Level 0 gives 1/8 duty; level 7 gives 8/8.
  - At frame_pos==7 (frame end):
    - if stop_pend, or this is the last frame of the last entry → FINISH;
    - else if rep_cnt==0 → idx++, rep_cnt=table[idx+1].repeat;
    - else rep_cnt--.
  - stop sets stop_pend. The current frame always completes; there is no truncated PWM period.
  - stop asserted on the frame_pos==7 cycle takes effect at that frame end.
  - start and clear are ignored in RUN.
- FINISH:
  - Lasts one cycle: done=1, o=0, busy=1.
  - Clears stop_pend, then → IDLE.
  - Table and count are retained, so start replays the same program.
- Timing:
  - start sampled at edge k → first RUN cycle is k+1 with frame_pos=0 and o=1.
  - Total RUN cycles = 8·Σ(repeat_i+1); done is high the cycle after the last RUN cycle.
- Width rules:
  - count is clog2(DEPTH)+1 bits.
  - idx and frame_pos wrap naturally; no overflow is reachable.

Decomposition:
- Shared package:
  - state enum (IDLE/RUN/FINISH);
  - FRAME_LEN=8 and LVL_W/REP_W defaults;
  - table entry struct {level, repeat}.
- One sub-module, pwm_frame_counter: LVL_W-bit up-counter with enable and synchronous clear, plus async active-low reset. It supplies frame_pos and a frame_end flag.
- Table storage, FSM and output compare stay in duty_sequencer.

Test Plan:
- Single entry (level 0, repeat 0), start → o=1 for 1 cycle, 0 for 7; done pulse on cycle 9 after start; busy low after.
- Entries (3,1), (7,0), start → two frames of 4 high/4 low, then 8 high; frame_start every 8 cycles; done at cycle 25.
- Write 8 entries back-to-back → wr_ready drops after the 8th; a 9th wr_valid is not accepted and count stays 8.
- Entry (5,15) playing, stop at frame_pos=3 of frame 2 → frame finishes through pos 7, then FINISH; done at the frame boundary; 16-frame program is cut short.
- Empty table + start → stays IDLE, busy=0; clear+start with 2 entries → count=0, no RUN; start+write on empty table → RUN with that one entry.
- reset pulled low at frame_pos=4 mid-RUN → o, busy and done go 0 immediately, state=IDLE, count=0; a following write+start runs normally.

Source files
------------

// File: rtl/duty_sequencer_pkg.sv
// Shared types and defaults for the duty sequencer: FSM states, frame geometry
// and the (level, repeat) table entry.
package duty_sequencer_pkg;

  localparam int FRAME_LEN = 8;
  localparam int LVL_W_DEF = $clog2(FRAME_LEN);
  localparam int REP_W_DEF = 4;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic [LVL_W_DEF-1:0] level;
    logic [REP_W_DEF-1:0] rpt;
  } entry_t;

endpackage

// File: rtl/duty_sequencer_pwm_frame_counter.sv
// Slot counter for one PWM frame: counts while enabled, wraps at the frame end
// and is held at slot 0 while cleared.
module pwm_frame_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_pos,
  output logic         o_frame_end
);

  logic [W-1:0] r_pos;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos <= '0;
    end else if (i_clr) begin
      r_pos <= '0;
    end else if (i_en) begin
      r_pos <= r_pos + W'(1);
    end
  end

  assign o_pos       = r_pos;
  assign o_frame_end = i_en && (r_pos == '1);

endmodule

// File: rtl/duty_sequencer.sv
// Plays a table of (duty level, repeat count) entries frame by frame and
// drives the PWM output; the table is loaded through a valid/ready port while idle.
module duty_sequencer
  import duty_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = LVL_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [LVL_W-1:0] wr_level,
  input  logic [REP_W-1:0] wr_repeat,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] frame_pos,
  output logic             frame_start,
  output logic             o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  logic [LVL_W-1:0] r_tbl_level [DEPTH];
  logic [REP_W-1:0] r_tbl_rep   [DEPTH];

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_idx;
  logic [REP_W-1:0] r_rep_cnt;
  logic [LVL_W-1:0] r_level;
  logic             r_o;
  logic             r_stop_pend;

  logic             w_run;
  logic             w_wr_fire;
  logic             w_frame_end;
  logic             w_last_entry;
  logic [LVL_W-1:0] w_frame_pos;
  logic [LVL_W-1:0] w_pos_nxt;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_run        = (r_state == ST_RUN);
  assign wr_ready     = (r_state == ST_IDLE) && (r_count < CNT_W'(DEPTH)) && !clear;
  assign w_wr_fire    = wr_valid && wr_ready;
  assign w_pos_nxt    = w_frame_pos + LVL_W'(1);
  assign w_idx_nxt    = r_idx + IDX_W'(1);
  assign w_last_entry = (CNT_W'(r_idx) + CNT_W'(1)) == r_count;

  pwm_frame_counter #(.W(LVL_W)) u_frame_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_run),
    .i_clr       (!w_run),
    .o_pos       (w_frame_pos),
    .o_frame_end (w_frame_end)
  );

  // NOTE: the table has no reset; entries at or above r_count are never read.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_tbl_level[r_count[IDX_W-1:0]] <= wr_level;
      r_tbl_rep[r_count[IDX_W-1:0]]   <= wr_repeat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_rep_cnt   <= '0;
      r_level     <= '0;
      r_o         <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_o <= 1'b0;
          if (clear) begin
            r_count <= '0;
          end else begin
            if (w_wr_fire) r_count <= r_count + CNT_W'(1);
            // An empty table may still start if entry 0 is being written now.
            if (start && ((r_count != '0) || w_wr_fire)) begin
              r_state   <= ST_RUN;
              r_idx     <= '0;
              r_rep_cnt <= (r_count == '0) ? wr_repeat : r_tbl_rep[0];
              r_level   <= (r_count == '0) ? wr_level  : r_tbl_level[0];
              r_o       <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_frame_end) begin
            if (r_stop_pend || stop || (w_last_entry && (r_rep_cnt == '0))) begin
              r_state <= ST_FINISH;
              r_o     <= 1'b0;
            end else begin
              // Slot 0 of every frame is high for any level.
              r_o <= 1'b1;
              if (r_rep_cnt == '0) begin
                r_idx     <= w_idx_nxt;
                r_rep_cnt <= r_tbl_rep[w_idx_nxt];
                r_level   <= r_tbl_level[w_idx_nxt];
              end else begin
                r_rep_cnt <= r_rep_cnt - REP_W'(1);
              end
            end
          end else begin
            r_o <= (w_pos_nxt <= r_level);
          end
        end
        ST_FINISH: begin
          r_o         <= 1'b0;
          r_stop_pend <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FINISH);
  assign level       = r_level;
  assign frame_pos   = w_frame_pos;
  assign frame_start = w_run && (w_frame_pos == '0);
  assign o           = r_o;

endmodule
